// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arb_pkg;

    // Arbiter state encoding.
    typedef enum logic [2:0] {
        StIdle,
        StGrantMem,
        StGrantIf,
        StDoneMem,
        StDoneIf
    } arb_state_e;

    // Owner of the most recently completed transaction.
    typedef enum logic {
        GntIf  = 1'b0,
        GntMem = 1'b1
    } arb_grant_e;

    // Byte-to-word address shift.
    localparam int unsigned WordOffset = 2;

endpackage

// File: rtl/mem_bus_arbiter_beat_counter.sv
// Loadable refill beat counter with a terminal-count flag.
// With a single-word line the counter collapses to a constant 0 that is always terminal.
module arb_beat_counter #(
    parameter int unsigned LineWords = 4,
    localparam int unsigned BeatW = (LineWords > 1) ? $clog2(LineWords) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [BeatW-1:0] beat_o,
    output logic             last_o
);

    if (LineWords > 1) begin : g_count
        logic [BeatW-1:0] cnt_q, cnt_d;

        // Clear has priority so a new grant always starts at beat 0.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (inc_i) begin
                cnt_d = cnt_q + BeatW'(1);
            end
        end

        // Beat count register, synchronous active-low reset.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign beat_o = cnt_q;
        assign last_o = (cnt_q == BeatW'(LineWords - 1));
    end else begin : g_single
        logic unused_ctl;
        assign unused_ctl = ^{clk_i, rst_ni, clear_i, inc_i};
        assign beat_o     = '0;
        assign last_o     = 1'b1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: instruction-line refill bursts vs single data accesses.
// Optional performance counters are compiled in with `define MEM_BUS_ARB_PERF_EN.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned LineWords = 4,
    parameter int unsigned AddrW     = 32,
    localparam int unsigned BeatW    = (LineWords > 1) ? $clog2(LineWords) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // Fetch refill requester
    input  logic             if_req_i,
    input  logic [AddrW-1:0] if_addr_i,
    output logic             if_rvalid_o,
    output logic [BeatW-1:0] if_beat_o,
    output logic [31:0]      if_rdata_o,
    output logic             if_done_o,
    // Data access requester
    input  logic             mem_req_i,
    input  logic             mem_we_i,
    input  logic [AddrW-1:0] mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    output logic [31:0]      mem_rdata_o,
    output logic             mem_done_o,
    // External memory bus
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [AddrW-1:0] bus_addr_o,
    output logic [31:0]      bus_wdata_o,
    input  logic             bus_ack_i,
    input  logic [31:0]      bus_rdata_i,
    // Hazard unit
    output logic             stall_if_o,
`ifdef MEM_BUS_ARB_PERF_EN
    output logic [31:0]      perf_if_lines_o,
    output logic [31:0]      perf_mem_acc_o,
    output logic [31:0]      perf_stall_cyc_o,
`endif
    output logic             stall_mem_o
);

    localparam int unsigned LineOffW = $clog2(LineWords) + WordOffset;

    arb_state_e       state_q, state_d;
    arb_grant_e       last_grant_q, last_grant_d;
    logic [AddrW-1:0] base_q, base_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [AddrW-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic [BeatW-1:0] if_beat_q, if_beat_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic             if_done_q, if_done_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic             mem_done_q, mem_done_d;

    logic             beat_clr, beat_inc, beat_last, ack_taken;
    logic [BeatW-1:0] beat_q, beat_nxt;

    // Offset bits below the word/line boundary are masked off by design.
    logic unused_addr;
    assign unused_addr = ^{if_addr_i[LineOffW-1:0], mem_addr_i[WordOffset-1:0]};

    arb_beat_counter #(
        .LineWords (LineWords)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (beat_clr),
        .inc_i   (beat_inc),
        .beat_o  (beat_q),
        .last_o  (beat_last)
    );

    // An ack only counts once the request is actually on the bus.
    assign ack_taken = bus_req_q & bus_ack_i;
    assign beat_nxt  = beat_q + BeatW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_rvalid_d  = 1'b0;
        if_beat_d    = if_beat_q;
        if_rdata_d   = if_rdata_q;
        if_done_d    = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        mem_done_d   = 1'b0;
        beat_clr     = 1'b0;
        beat_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus_req_d = 1'b0;
                // On contention the requester that did not go last wins.
                if (mem_req_i && (!if_req_i || last_grant_q == GntIf)) begin
                    state_d     = StGrantMem;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = {mem_addr_i[AddrW-1:WordOffset], {WordOffset{1'b0}}};
                    bus_wdata_d = mem_wdata_i;
                end else if (if_req_i) begin
                    state_d     = StGrantIf;
                    base_d      = {if_addr_i[AddrW-1:LineOffW], {LineOffW{1'b0}}};
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {if_addr_i[AddrW-1:LineOffW], {LineOffW{1'b0}}};
                    bus_wdata_d = '0;
                    beat_clr    = 1'b1;
                end
            end
            StGrantMem: begin
                bus_req_d = 1'b1;
                if (ack_taken) begin
                    bus_req_d    = 1'b0;
                    mem_rdata_d  = bus_rdata_i;
                    mem_done_d   = 1'b1;
                    last_grant_d = GntMem;
                    state_d      = StDoneMem;
                end
            end
            StGrantIf: begin
                bus_req_d = 1'b1;
                if (ack_taken) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = bus_rdata_i;
                    if_beat_d   = beat_q;
                    beat_inc    = 1'b1;
                    if (beat_last) begin
                        bus_req_d    = 1'b0;
                        if_done_d    = 1'b1;
                        last_grant_d = GntIf;
                        state_d      = StDoneIf;
                    end else begin
                        bus_addr_d = base_q + (AddrW'(beat_nxt) << WordOffset);
                    end
                end
            end
            StDoneMem, StDoneIf: begin
                bus_req_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= GntIf;
            base_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_beat_q    <= '0;
            if_rdata_q   <= '0;
            if_done_q    <= 1'b0;
            mem_rdata_q  <= '0;
            mem_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            if_beat_q    <= if_beat_d;
            if_rdata_q   <= if_rdata_d;
            if_done_q    <= if_done_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_done_q   <= mem_done_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_beat_o   = if_beat_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_done_o   = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign stall_if_o  = if_req_i & ~if_done_q;
    assign stall_mem_o = mem_req_i & ~mem_done_q;

`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_mem_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_if_q    <= '0;
            perf_mem_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_done_q && perf_if_q != '1) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (mem_done_q && perf_mem_q != '1) begin
                perf_mem_q <= perf_mem_q + 32'd1;
            end
            if ((stall_if_o || stall_mem_o) && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_if_lines_o  = perf_if_q;
    assign perf_mem_acc_o   = perf_mem_q;
    assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (default 4-word lines, 32-bit addresses).
module tb_mem_bus_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [1:0]  if_beat;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_if;
    logic        stall_mem;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_if_lines, perf_mem_acc, perf_stall_cyc;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    mem_bus_arbiter #(
        .LineWords (LW),
        .AddrW     (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rvalid_o (if_rvalid),
        .if_beat_o   (if_beat),
        .if_rdata_o  (if_rdata),
        .if_done_o   (if_done),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata),
        .stall_if_o  (stall_if),
`ifdef MEM_BUS_ARB_PERF_EN
        .perf_if_lines_o  (perf_if_lines),
        .perf_mem_acc_o   (perf_mem_acc),
        .perf_stall_cyc_o (perf_stall_cyc),
`endif
        .stall_mem_o (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until bus_req rises; an expired bound shows up as a wrong count.
    task automatic wait_bus(input string tag, input int exp_cycles);
        int n = 0;
        while (!bus_req && n < 20) begin
            cyc();
            n++;
        end
        check_val(tag, 64'(n), 64'(exp_cycles));
    endtask

    // Complete a data access; entered on the first cycle bus_req is high.
    task automatic mem_txn(input logic we, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] rdata,
                           input int waits);
        check_val("mem_bus_req", bus_req, 1'b1);
        check_val("mem_bus_we", bus_we, we);
        check_val("mem_bus_addr", bus_addr, exp_addr);
        check_val("mem_bus_wdata", bus_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            mem_addr  = 32'hFFFF_FFFC;
            mem_wdata = 32'hFFFF_FFFF;
            cyc();
            check_val("mem_wait_addr", bus_addr, exp_addr);
            check_val("mem_wait_wdata", bus_wdata, exp_wdata);
            check_val("mem_wait_done", mem_done, 1'b0);
            check_val("mem_wait_stall", stall_mem, 1'b1);
        end
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        cyc();
        check_val("mem_done", mem_done, 1'b1);
        if (!we) check_val("mem_rdata", mem_rdata, rdata);
        check_val("mem_done_bus_req", bus_req, 1'b0);
        check_val("mem_done_stall", stall_mem, 1'b0);
        mem_req = 1'b0;
        bus_ack = 1'b0;
        cyc();
        check_val("mem_done_pulse", mem_done, 1'b0);
    endtask

    // Run a full refill burst; entered on the first cycle bus_req is high.
    // mem_req is raised at beat pend_at (LW = never).
    task automatic refill_beats(input logic [31:0] base, input int pend_at);
        for (int b = 0; b < LW; b++) begin
            if (b == pend_at) mem_req = 1'b1;
            check_val("rf_bus_req", bus_req, 1'b1);
            check_val("rf_bus_we", bus_we, 1'b0);
            check_val("rf_bus_addr", bus_addr, base + 32'(4 * b));
            bus_ack   = 1'b1;
            bus_rdata = 32'hC0DE_0000 + base + 32'(b);
            cyc();
            check_val("rf_rvalid", if_rvalid, 1'b1);
            check_val("rf_beat", if_beat, 64'(b));
            check_val("rf_rdata", if_rdata, 32'hC0DE_0000 + base + 32'(b));
            check_val("rf_done", if_done, (b == LW - 1));
            if (b >= pend_at) check_val("rf_stall_mem", stall_mem, 1'b1);
        end
        check_val("rf_end_bus_req", bus_req, 1'b0);
        check_val("rf_end_stall_if", stall_if, 1'b0);
        if_req  = 1'b0;
        bus_ack = 1'b0;
        cyc();
        check_val("rf_done_pulse", if_done, 1'b0);
        check_val("rf_rvalid_off", if_rvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        cyc();
        cyc();
        check_val("rst_bus_req", bus_req, 1'b0);
        check_val("rst_bus_addr", bus_addr, 32'h0);
        check_val("rst_if_rvalid", if_rvalid, 1'b0);
        check_val("rst_if_done", if_done, 1'b0);
        check_val("rst_mem_done", mem_done, 1'b0);
        check_val("rst_mem_rdata", mem_rdata, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Load, acked on the first bus cycle: done lands three cycles after the request.
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_1004;
        mem_wdata = 32'h0;
        #1;
        check_val("load_stall", stall_mem, 1'b1);
        wait_bus("load_grant_lat", 2);
        mem_txn(1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);

        // Store with 3 wait cycles; acks while bus_req is low must be ignored.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_2003;
        mem_wdata = 32'h1234_5678;
        bus_ack   = 1'b1;
        cyc();
        check_val("store_grant_bus_req", bus_req, 1'b0);
        check_val("store_early_ack", mem_done, 1'b0);
        bus_ack = 1'b0;
        cyc();
        mem_txn(1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0, 3);

        // Refill from a mid-line address.
        if_req  = 1'b1;
        if_addr = 32'h0000_0108;
        #1;
        check_val("rf_stall_if", stall_if, 1'b1);
        wait_bus("rf_grant_lat", 2);
        refill_beats(32'h0000_0100, LW);

        // Reset at beat 2 abandons the burst; a fresh request restarts at beat 0.
        if_req  = 1'b1;
        if_addr = 32'h0000_0304;
        wait_bus("rr_grant_lat", 2);
        for (int b = 0; b < 2; b++) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'h5A00_0000 + 32'(b);
            cyc();
        end
        check_val("rr_beat2_addr", bus_addr, 32'h0000_0308);
        rst_n = 1'b0;
        cyc();
        check_val("rr_bus_req", bus_req, 1'b0);
        check_val("rr_bus_addr", bus_addr, 32'h0);
        check_val("rr_if_rvalid", if_rvalid, 1'b0);
        check_val("rr_if_rdata", if_rdata, 32'h0);
        check_val("rr_if_beat", if_beat, 2'd0);
        check_val("rr_if_done", if_done, 1'b0);
        rst_n   = 1'b1;
        bus_ack = 1'b0;
        wait_bus("rr_restart_lat", 2);
        refill_beats(32'h0000_0300, LW);

        // Contention straight after reset: data path first.
        rst_n = 1'b0;
        cyc();
        rst_n     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0200;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_3000;
        mem_wdata = 32'h0;
        wait_bus("ct_grant_lat", 2);
        check_val("ct_stall_if", stall_if, 1'b1);
        mem_txn(1'b0, 32'h0000_3000, 32'h0, 32'h0000_0055, 0);
        // Both pending again: fetch now wins, data request waits through the burst.
        mem_req  = 1'b1;
        mem_addr = 32'h0000_3100;
        wait_bus("ct_if_lat", 2);
        refill_beats(32'h0000_0200, 0);
        wait_bus("ct_mem_lat", 2);
        mem_txn(1'b0, 32'h0000_3100, 32'h0, 32'h0000_0066, 0);

        // Data request raised at beat 1 of a burst: no preemption.
        if_req   = 1'b1;
        if_addr  = 32'h0000_041C;
        mem_addr = 32'h0000_4008;
        mem_we   = 1'b1;
        mem_wdata = 32'hCAFE_F00D;
        wait_bus("mb_if_lat", 2);
        refill_beats(32'h0000_0410, 1);
        #1;
        check_val("mb_stall_wait", stall_mem, 1'b1);
        wait_bus("mb_mem_lat", 2);
        mem_txn(1'b1, 32'h0000_4008, 32'hCAFE_F00D, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external word-wide memory bus between two requesters: the instruction-fetch refill path (line bursts) and the data-access path (single-word load/store).
- Sits between the IF/MEM pipeline stages and main memory.
- Returns per-requester done pulses and read data.
- Drives stall requests into the hazard unit while a requester is waiting.

Parameters:
- LINE_WORDS, 4: words per instruction-line refill. Power of two, >= 1.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch refill request; level, held until if_done
- if_addr  in  ADDR_W  fetch miss address; any byte within the line
- if_rvalid  out  1  one refill beat valid this cycle
- if_beat  out  log2(LINE_WORDS) (min 1)  word index of the current beat
- if_rdata  out  32  refill beat data
- if_done  out  1  one-cycle pulse; refill complete
- mem_req  in  1  data access request; level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data word address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data; valid while mem_done is high
- mem_done  out  1  one-cycle pulse; access complete
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  bus word address; bits [1:0] always 0
- bus_wdata  out  32  bus write data
- bus_ack  in  1  beat accepted/returned this cycle
- bus_rdata  in  32  read data, valid when bus_ack is high
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  mem_req & ~mem_done

Behaviour:
- Reset (rst == 0 at a clk edge): state IDLE, last_grant = IF, beat counter 0. All registered outputs go to 0 (bus_*, if_*, mem_*). Reset mid-burst abandons the transaction with no done pulse.
- States and transitions:
  - IDLE: bus_req = 0.
    - mem_req only → GRANT_MEM.
    - if_req only → GRANT_IF.
    - Both → grant the requester other than last_grant.
    - Latch address/data on entry.
    - In GRANT_IF the latched base = if_addr with the low log2(LINE_WORDS*4) bits cleared; beat = 0.
  - GRANT_MEM: bus_req = 1, bus_we = mem_we, bus_addr = {latched mem_addr[ADDR_W-1:2], 2'b00}, bus_wdata = latched mem_wdata.
    - On bus_ack: capture bus_rdata → DONE_MEM; last_grant = MEM.
  - GRANT_IF: bus_req = 1, bus_we = 0, bus_addr = base + beat*4.
    - Each bus_ack: next cycle if_rvalid = 1, if_rdata = captured data, if_beat = beat; beat increments.
    - On the ack where beat == LINE_WORDS-1 → DONE_IF; last_grant = IF.
  - DONE_MEM / DONE_IF: bus_req = 0; pulse mem_done / if_done for exactly one cycle → IDLE. The requester drops req on that same edge.
- Latency:
  - Grant occurs on the cycle after the request.
  - Done occurs 1 cycle after the final ack.
  - Bus idles at least 1 cycle between transactions.
  - Single access with ack on its first bus cycle: req at cycle 0 → mem_done at cycle 3.
- No preemption: a mem_req arriving mid-burst waits; stall_mem stays high.
- bus_ack while bus_req == 0 is ignored.
- Request address/data changes while granted are ignored; latched values are used.
- LINE_WORDS == 1: refill is a single beat; if_beat is tied 0.
- Beat counter wraps only via the reset-to-0 on a new grant; no overflow is possible.

Optional Feature:
- Macro: MEM_BUS_ARB_PERF_EN.
- Defined: adds outputs perf_if_lines (32), perf_mem_acc (32) and perf_stall_cyc (32).
  - perf_if_lines: +1 per if_done.
  - perf_mem_acc: +1 per mem_done.
  - perf_stall_cyc: +1 per cycle with stall_if | stall_mem.
  - All three are saturating, cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - the state encoding (IDLE, GRANT_MEM, GRANT_IF, DONE_MEM, DONE_IF);
  - the grant-owner constants GNT_IF / GNT_MEM;
  - the word-offset constant (2).
- One sub-module, arb_beat_counter: loadable beat counter with terminal-count flag, parameterised by LINE_WORDS.

Test Plan:
- Load: mem_req=1, mem_we=0, mem_addr=0x1004; bus acks on the first bus_req cycle with 0xDEADBEEF → bus_addr=0x1004, mem_done one cycle, mem_rdata=0xDEADBEEF, stall_mem low after done.
- Store: mem_we=1, mem_addr=0x2003, mem_wdata=0x12345678; ack after 3 wait cycles → bus_we=1, bus_addr=0x2000, bus_wdata=0x12345678, mem_done 1 cycle after ack.
- Refill: LINE_WORDS=4, if_addr=0x0000_0108 → bus_addr 0x100, 0x104, 0x108, 0x10C in order; if_beat 0..3 with matching if_rdata; single if_done.
- Contention: if_req and mem_req rise in the same cycle after reset → MEM served first, then IF. Repeat both pending → IF served first (alternation).
- Mid-burst data request: mem_req raised at beat 1 → burst completes uninterrupted, then mem granted; stall_mem high throughout the wait.
- Reset at beat 2 of a refill → next cycle all outputs 0, no if_done; a fresh if_req restarts at beat 0.
